fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised next-generation instruction fetch stage.
- Holds the PC and issues word reads to a 1-cycle-latency synchronous instruction memory.
- Buffers returned instructions in a DEPTH-entry queue, presented to decode with a valid/ready handshake.
- Accepts redirects (mispredict/trap) from the memory/branch stage; an optional static predictor redirects on the fetch side.

Parameters:
- RESET_PC, 32'h00000040, PC loaded on reset.
- DEPTH, 4, queue entries; power of two, >= 2.
- IMEM_AW, 8, imem word-address width; imem_addr = pc[IMEM_AW+1:2].

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_addr  out  IMEM_AW  word address of read.
- imem_read  out  1  read strobe; data returns on imem_data the following cycle.
- imem_data  in  32  read data, valid the cycle after imem_read.
- redirect  in  1  mispredict/trap redirect from mb stage.
- redirect_target  in  32  new PC when redirect=1.
- pipe_flush  out  1  registered; tells downstream to squash.
- if_id__valid  out  1  queue head valid.
- if_id__ready  in  1  decode accepts head.
- if_id__pc  out  32  head PC.
- if_id__ins  out  32  head instruction.
- if_id__ins_misalign  out  1  head entry came from a misaligned PC.
- if_id__predict_taken  out  1  head entry was predicted taken.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC; queue empty (if_id__valid=0); inflight=0; halted=0; pipe_flush=1.
  - if_id__pc/ins/misalign/predict_taken read 0 when empty.
  - Reset overrides redirect and every other input.
- Occupancy: count (0..DEPTH) plus inflight (0/1). pop = if_id__valid && if_id__ready.
- Issue: imem_read=1 iff !halted && !redirect && pc[1:0]==0 && (count + inflight - pop) < DEPTH.
  - On issue: pc <= pc+4 (32-bit wrap); record req_pc=pc; inflight <= 1.
  - With count=1 steady state and continuous pop, one instruction per cycle (no bubble) for DEPTH >= 2.
- Response: the cycle after issue, push {req_pc, imem_data, 0, pred} at tail unless squashed. inflight clears.
- Simultaneous push and pop: both occur; count unchanged. Push into a full queue is impossible by the credit rule; the bench asserts this never happens.
- Misalign: if pc[1:0]!=0 and not halted and count-with-pop < DEPTH and inflight=0:
  - Push {pc, 32'h00000013, 1, 0}; halted <= 1.
  - No imem_read while halted; only redirect clears halted.
- Redirect (has priority over all but reset):
  - Queue cleared (count=0, if_id__valid=0 next cycle).
  - Any in-flight response is discarded; pc <= redirect_target; halted <= 0.
  - pipe_flush <= 1 for exactly the following cycle; otherwise pipe_flush <= 0.
  - A pop in the redirect cycle is still a valid handshake.
- Back-to-back redirects: the last one wins; pipe_flush stays 1.
- Queue pointers wrap modulo DEPTH.

Optional Feature:
- Macro: FETCH_STATIC_PREDICT_EN.
- Defined: each unsquashed response is decoded.
  - JAL (opcode 1101111): predicted taken, target = req_pc + J-imm.
  - BRANCH (1100011) with imm[12]=1: predicted taken, target = req_pc + B-imm.
  - On predicted taken: entry pushed with predict_taken=1; pc <= target.
  - The read issued in that same cycle is suppressed: imem_read forced 0, pc not incremented.
  - A misaligned target takes the misalign path next cycle.
  - An external redirect in the same cycle overrides the prediction, and the response is dropped.
- Undefined: predict_taken always 0; no fetch-side redirects.

Test Plan:
- Reset then ready=1, imem returns word index: first accepted pc=0x40, 0x44, 0x48; one per cycle after 2-cycle startup latency; pipe_flush 1 only on the first cycle.
- ready=0 for 10 cycles with DEPTH=4: exactly 4 entries buffered, imem_read=0 afterwards; ready=1 drains 0x40..0x4C in order with no loss or duplicates.
- redirect=1, target 0x200, while queue holds 3 entries and a read is in flight: next cycle valid=0, pipe_flush=1; next issued addr=0x200>>2; stale response never appears.
- redirect target 0x202: one entry {pc=0x202, ins=0x00000013, misalign=1}; no further imem_read until redirect to 0x300 resumes fetch.
- FETCH_STATIC_PREDICT_EN with JAL +0x20 at 0x40: entries 0x40 (predict_taken=1) then 0x60; 0x44 never delivered. Backward BEQ is predicted taken; forward BEQ is not.
- rst_n=0 asserted together with redirect mid-drain: next cycle pc=RESET_PC, queue empty, pipe_flush=1, first read is from 0x40.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Decode-facing fetch handshake: queue head payload with valid/ready.
interface fetch_queue_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        ins_misalign;
  logic        predict_taken;

  modport master (output valid, pc, ins, ins_misalign, predict_taken, input ready);
  modport slave  (input valid, pc, ins, ins_misalign, predict_taken, output ready);
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, 1-cycle imem reads, DEPTH-entry queue towards decode.
// Define FETCH_STATIC_PREDICT_EN to enable the fetch-side static JAL/backward-branch predictor.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0040,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_read,
  input  logic [31:0]        imem_data,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  output logic               pipe_flush,
  fetch_queue_if.master      if_id
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        misalign;
    logic        pred;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_q, pc_d, req_pc_q, req_pc_d;
  logic               inflight_q, inflight_d;
  logic               halted_q, halted_d;
  logic               pipe_flush_q, pipe_flush_d;

  logic               pop, push, issue, resp_valid, misalign_push;
  logic               pred_taken;
  logic [31:0]        pred_target;
  logic [OCC_W-1:0]   occ, occ_after_pop;
  entry_t             push_entry, head_entry;

  // Static prediction on the returning word; inert unless the feature is built in.
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
`ifdef FETCH_STATIC_PREDICT_EN
    if (resp_valid) begin
      if (imem_data[6:0] == 7'b1101111) begin
        pred_taken  = 1'b1;
        pred_target = req_pc_q + {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                                  imem_data[20], imem_data[30:21], 1'b0};
      end else if (imem_data[6:0] == 7'b1100011 && imem_data[31]) begin
        pred_taken  = 1'b1;
        pred_target = req_pc_q + {{19{imem_data[31]}}, imem_data[31], imem_data[7],
                                  imem_data[30:25], imem_data[11:8], 1'b0};
      end
    end
`endif
  end

  // Next-state: credit-based issue, response/misalign push, redirect squash.
  always_comb begin
    mem_d        = mem_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    inflight_d   = 1'b0;
    halted_d     = halted_q;
    pipe_flush_d = redirect;

    pop           = (count_q != '0) && if_id.ready;
    resp_valid    = inflight_q && !redirect;
    occ           = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    occ_after_pop = OCC_W'(count_q) - OCC_W'(pop);
    issue         = !halted_q && !redirect && !pred_taken && (pc_q[1:0] == 2'b00) &&
                    (occ < OCC_W'(DEPTH));
    misalign_push = !halted_q && !redirect && (pc_q[1:0] != 2'b00) && !inflight_q &&
                    (occ_after_pop < OCC_W'(DEPTH));
    push          = resp_valid || misalign_push;
    push_entry    = misalign_push ? {pc_q, NOP_INS, 1'b1, 1'b0}
                                  : {req_pc_q, imem_data, 1'b0, pred_taken};

    if (push) begin
      mem_d[tail_q] = push_entry;
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (issue) begin
      pc_d       = pc_q + 32'd4;
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
    if (pred_taken)    pc_d     = pred_target;
    if (misalign_push) halted_d = 1'b1;

    if (redirect) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      pc_d     = redirect_target;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inflight_q   <= 1'b0;
      halted_q     <= 1'b0;
      pipe_flush_q <= 1'b1;
    end else begin
      mem_q        <= mem_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inflight_q   <= inflight_d;
      halted_q     <= halted_d;
      pipe_flush_q <= pipe_flush_d;
    end
  end

  // Head fields read as zero while the queue is empty.
  always_comb begin
    head_entry = (count_q != '0) ? mem_q[head_q] : '0;
  end

  assign imem_read           = issue;
  assign imem_addr           = pc_q[IMEM_AW+1:2];
  assign pipe_flush          = pipe_flush_q;
  assign if_id.valid         = (count_q != '0);
  assign if_id.pc            = head_entry.pc;
  assign if_id.ins           = head_entry.ins;
  assign if_id.ins_misalign  = head_entry.misalign;
  assign if_id.predict_taken = head_entry.pred;

endmodule
